pll_cpu_reset_seq: RTL and testbench

- Power-up and lock-supervision sequencer for the CPU clock PLL (25 MHz in, 18.432 MHz out).
- Runs on the stable 25 MHz reference clock. Drives the PLL's active-low RESETB and consumes its LOCK output.
- Releases the Z8S180 reset only after LOCK has been continuously stable; re-asserts it on any loss of lock.
- Retries the PLL on lock timeout and flags a persistent fault.

---
 rtl/pll_cpu_reset_seq.sv | 172 +++++++++++++++++
 tb/tb_pll_cpu_reset_seq.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cpu_reset_seq.sv
`timescale 1ns/1ps
// pll_cpu_reset_seq
// Power-up and lock-supervision sequencer for the CPU clock PLL.
// Runs on the 25 MHz reference clock, pulses the PLL's active-low reset,
// waits for a synchronized LOCK and holds the CPU in reset until LOCK has
// been continuously high for STABLE_CYCLES. Any loss of lock puts the CPU
// back into reset. A lock timeout retries the PLL reset and bumps a
// saturating retry counter. FAULT goes sticky when that counter saturates.
//
// DBG_STATE exposes the sequencer state for checkers:
//   0 = PLL_RST, 1 = WAIT_LOCK, 2 = STABLE, 3 = RUN.
//
// Handshake: there is no valid/ready pairing here. SOFT_RST is a single-cycle
// request that is sampled on every CLK edge and acted on only in RUN. All
// outputs are plain registered levels.
module pll_cpu_reset_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_WIDTH     = 16,
  parameter int RETRY_WIDTH   = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   PLL_LOCK,
  input  logic                   SOFT_RST,
  output logic                   PLL_RESETB,
  output logic                   CPU_RESETN,
  output logic                   READY,
  output logic                   FAULT,
  output logic [RETRY_WIDTH-1:0] RETRY_COUNT,
  output logic [1:0]             DBG_STATE
);

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  // Terminal compare values for the shared counter. Each state leaves on its
  // own terminal value, so the counter never wraps.
  localparam logic [CNT_WIDTH-1:0] RST_LAST     = CNT_WIDTH'(RST_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [RETRY_WIDTH-1:0] retry_q, retry_d;
  logic                   fault_q, fault_d;
  logic                   pll_resetb_q, pll_resetb_d;
  logic                   cpu_resetn_q, cpu_resetn_d;
  logic                   ready_q, ready_d;

  // Two-stage synchronizer for the asynchronous PLL LOCK.
  logic                   lock_meta_q, lock_meta_d;
  logic                   lock_s_q, lock_s_d;

  // Synchronizer next values: shift PLL_LOCK through two flops.
  always_comb begin
    lock_meta_d = PLL_LOCK;
    lock_s_d    = lock_meta_q;
  end

  // Next-state, counter, retry/fault and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    fault_d = fault_q;

    case (state_q)
      ST_PLL_RST: begin
        // PLL held in reset for exactly RST_CYCLES cycles.
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Lock never came: pulse the PLL again. Retries continue even
          // after FAULT is raised.
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          if (!(&retry_q)) begin
            retry_d = retry_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STABLE: begin
        // Any single low cycle of lock_s restarts qualification from WAIT_LOCK.
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        // Lock loss takes priority over a simultaneous soft reset request.
        if (!lock_s_q) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (SOFT_RST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // FAULT is set on the edge where the retry counter becomes all-ones.
    fault_d = fault_q | (&retry_d);

    // Outputs follow the state being entered so they change on the same edge.
    pll_resetb_d = (state_d != ST_PLL_RST);
    cpu_resetn_d = (state_d == ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  // State, counter and output registers with dominant synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      fault_q      <= 1'b0;
      pll_resetb_q <= 1'b0;
      cpu_resetn_q <= 1'b0;
      ready_q      <= 1'b0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      fault_q      <= fault_d;
      pll_resetb_q <= pll_resetb_d;
      cpu_resetn_q <= cpu_resetn_d;
      ready_q      <= ready_d;
      lock_meta_q  <= lock_meta_d;
      lock_s_q     <= lock_s_d;
    end
  end

  assign PLL_RESETB  = pll_resetb_q;
  assign CPU_RESETN  = cpu_resetn_q;
  assign READY       = ready_q;
  assign FAULT       = fault_q;
  assign RETRY_COUNT = retry_q;
  assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_pll_cpu_reset_seq.sv
`timescale 1ns/1ps
// Bench for pll_cpu_reset_seq: directed scenarios followed by random lock /
// soft-reset / reset traffic, with every cycle compared against a
// behavioural model of the sequencing rules.
module tb_pll_cpu_reset_seq;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int CNT_WIDTH     = 16;
  localparam int RETRY_WIDTH   = 2;
  localparam int RETRY_MAX     = (1 << RETRY_WIDTH) - 1;
  localparam int W             = 4 + RETRY_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic                   reset;
  logic                   pll_lock;
  logic                   soft_rst;
  logic                   PLL_RESETB;
  logic                   CPU_RESETN;
  logic                   READY;
  logic                   FAULT;
  logic [RETRY_WIDTH-1:0] RETRY_COUNT;
  logic [1:0]             dbg_state;

  pll_cpu_reset_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_WIDTH    (CNT_WIDTH),
    .RETRY_WIDTH  (RETRY_WIDTH)
  ) dut (
    .CLK        (clk),
    .RESET      (reset),
    .PLL_LOCK   (pll_lock),
    .SOFT_RST   (soft_rst),
    .PLL_RESETB (PLL_RESETB),
    .CPU_RESETN (CPU_RESETN),
    .READY      (READY),
    .FAULT      (FAULT),
    .RETRY_COUNT(RETRY_COUNT),
    .DBG_STATE  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Lock history: the value used at an edge is PLL_LOCK as sampled two edges earlier.
  bit lq[$] = '{1'b0, 1'b0};
  int m_pulse_left = RST_CYCLES;  // cycles of PLL reset still to go (0 = PLL released)
  bit m_waiting    = 1'b0;
  int m_wait_age   = 0;
  bit m_qualifying = 1'b0;
  int m_qual_age   = 0;
  bit m_running    = 1'b0;
  int m_retries    = 0;
  bit m_fault      = 1'b0;

  task automatic model_step();
    bit ls;
    if (reset) begin
      lq           = '{1'b0, 1'b0};
      m_pulse_left = RST_CYCLES;
      m_waiting    = 1'b0;
      m_qualifying = 1'b0;
      m_running    = 1'b0;
      m_wait_age   = 0;
      m_qual_age   = 0;
      m_retries    = 0;
      m_fault      = 1'b0;
    end else begin
      ls = lq.pop_front();
      lq.push_back(pll_lock);
      if (m_pulse_left > 0) begin
        m_pulse_left--;
        if (m_pulse_left == 0) begin
          m_waiting  = 1'b1;
          m_wait_age = 0;
        end
      end else if (m_waiting) begin
        if (ls) begin
          m_waiting    = 1'b0;
          m_qualifying = 1'b1;
          m_qual_age   = 0;
        end else if (m_wait_age == LOCK_TIMEOUT - 1) begin
          m_waiting    = 1'b0;
          m_pulse_left = RST_CYCLES;
          if (m_retries < RETRY_MAX) m_retries++;
          if (m_retries == RETRY_MAX) m_fault = 1'b1;
        end else begin
          m_wait_age++;
        end
      end else if (m_qualifying) begin
        if (!ls) begin
          m_qualifying = 1'b0;
          m_waiting    = 1'b1;
          m_wait_age   = 0;
        end else if (m_qual_age == STABLE_CYCLES - 1) begin
          m_qualifying = 1'b0;
          m_running    = 1'b1;
        end else begin
          m_qual_age++;
        end
      end else if (m_running) begin
        if (!ls) begin
          m_running  = 1'b0;
          m_waiting  = 1'b1;
          m_wait_age = 0;
        end else if (soft_rst) begin
          m_running    = 1'b0;
          m_qualifying = 1'b1;
          m_qual_age   = 0;
        end
      end
    end
    exp_q.push_back({(m_pulse_left == 0), m_running, m_running, m_fault,
                     RETRY_WIDTH'(m_retries)});
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model follows the edge, outputs compared 1 ns later.
  task automatic tick();
    logic [W-1:0] exp;
    @(posedge clk);
    model_step();
    #1;
    exp = exp_q.pop_front();
    check("outputs", {PLL_RESETB, CPU_RESETN, READY, FAULT, RETRY_COUNT}, exp);
  endtask

  function automatic logic probe(input int which);
    case (which)
      0:       return PLL_RESETB;
      1:       return CPU_RESETN;
      default: return READY;
    endcase
  endfunction

  // Clock until the probed output reaches val; n = edges taken (bound on expiry).
  task automatic ticks_until(input int which, input logic val, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (probe(which) !== val && n < bound);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   n;
    int   hold;
    logic rb_ok;
    logic rdy_ok;

    reset    = 1'b1;
    pll_lock = 1'b0;
    soft_rst = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {PLL_RESETB, CPU_RESETN, READY, FAULT, RETRY_COUNT}, 0);
    check("dbg_state_reset", dbg_state, 0);

    // Normal power-up.
    reset = 1'b0;
    ticks_until(0, 1'b1, 50, n);
    check("pll_resetb_low_len", n, RST_CYCLES);
    repeat (10) tick();
    pll_lock = 1'b1;
    ticks_until(1, 1'b1, 100, n);
    check("cpu_release_latency", n, 2 + 1 + STABLE_CYCLES);
    check("ready_with_release", READY, 1);
    repeat (5) tick();
    check("run_held", {CPU_RESETN, READY}, 2'b11);

    // Reset mid-RUN for 3 cycles; lock stays high.
    reset = 1'b1;
    tick();
    check("reset_mid_run", {PLL_RESETB, CPU_RESETN, READY, FAULT, RETRY_COUNT}, 0);
    repeat (2) tick();
    reset = 1'b0;
    ticks_until(2, 1'b1, 100, n);
    check("rerun_after_reset", n, RST_CYCLES + 1 + STABLE_CYCLES);

    // One-cycle lock loss in RUN.
    repeat (3) tick();
    pll_lock = 1'b0;
    tick();
    n = 1;
    pll_lock = 1'b1;
    while (CPU_RESETN !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    check("loss_to_cpu_reset", n, 3);
    ticks_until(1, 1'b1, 100, n);
    check("relock_release", n, 1 + STABLE_CYCLES);
    check("retry_after_loss", RETRY_COUNT, 0);

    // SOFT_RST pulse in RUN: window counted from the request cycle.
    repeat (3) tick();
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    n = 1;
    check("soft_asserts", CPU_RESETN, 0);
    rb_ok  = PLL_RESETB;
    rdy_ok = (READY === CPU_RESETN);
    while (CPU_RESETN !== 1'b1 && n < 50) begin
      tick();
      n++;
      rb_ok  = rb_ok & PLL_RESETB;
      rdy_ok = rdy_ok & (READY === CPU_RESETN);
    end
    check("soft_window", n, STABLE_CYCLES + 1);
    check("soft_pll_untouched", rb_ok, 1);
    check("soft_ready_tracks", rdy_ok, 1);

    // Glitch while qualifying: lock_s seen low when the stable count is 5.
    repeat (3) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (6) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    ticks_until(1, 1'b1, 100, n);
    check("glitch_requalify", n, 3 + STABLE_CYCLES);
    check("retry_after_glitch", RETRY_COUNT, 0);

    // Lock held low: timeouts, retries, fault; soft request ignored in WAIT_LOCK.
    repeat (3) tick();
    pll_lock = 1'b0;
    ticks_until(1, 1'b0, 20, n);
    check("loss_before_timeout", n, 3);
    for (int k = 1; k <= 4; k++) begin
      n = 0;
      do begin
        soft_rst = (k == 1 && n == 5);
        tick();
        soft_rst = 1'b0;
        n++;
        if (k == 1 && n == 6) check("soft_ignored_in_wait", {PLL_RESETB, CPU_RESETN}, 2'b10);
      end while (PLL_RESETB !== 1'b0 && n < 60);
      check("wait_len", n, LOCK_TIMEOUT);
      check("retry_count", RETRY_COUNT, (k > RETRY_MAX) ? RETRY_MAX : k);
      check("fault", FAULT, (k >= RETRY_MAX) ? 1 : 0);
      ticks_until(0, 1'b1, 20, n);
      check("pll_rst_pulse", n, RST_CYCLES);
    end
    pll_lock = 1'b1;
    ticks_until(2, 1'b1, 200, n);
    check("run_despite_fault", n, 2 + 1 + STABLE_CYCLES);
    check("fault_sticky", FAULT, 1);

    // Random traffic checked every cycle against the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        pll_lock = ($urandom_range(0, 9) < 7);
        hold     = $urandom_range(1, 40);
      end
      hold--;
      soft_rst = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset    = 1'b0;
    soft_rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
